// File: rtl/serial_and_reducer.sv
// Bit-serial AND reducer: registers a&b per accepted pair, reports packet AND/OR/length.
// Optional ones counter enabled by defining SERIAL_AND_REDUCER_ONES_EN.
module serial_and_reducer #(
    parameter  int MAX_LEN = 16,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          a,
    input  logic          b,
    input  logic          in_last,
    output logic          bit_valid,
    output logic          bit_o,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_all,
    output logic          res_any,
    output logic [LW-1:0] res_len,
    output logic          res_ovf
`ifdef SERIAL_AND_REDUCER_ONES_EN
    ,
    output logic [LW-1:0] res_ones
`endif
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          ab;
    logic          acc_all;
    logic          acc_any;
    logic [LW-1:0] acc_len;
    logic          acc_ovf;
    logic          len_full;
    logic          fin_all;
    logic          fin_any;
    logic [LW-1:0] fin_len;
    logic          fin_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        unique case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign res_valid = (state_q == HOLD);

    // Final values fold in the closing pair so the last bit is never lost.
    assign ab       = a & b;
    assign len_full = (acc_len == LEN_MAX);
    assign fin_all  = acc_all & ab;
    assign fin_any  = acc_any | ab;
    assign fin_len  = len_full ? acc_len : acc_len + 1'b1;
    assign fin_ovf  = acc_ovf | len_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_valid <= 1'b0;
            bit_o     <= 1'b0;
            acc_all   <= 1'b1;
            acc_any   <= 1'b0;
            acc_len   <= '0;
            acc_ovf   <= 1'b0;
            res_all   <= 1'b0;
            res_any   <= 1'b0;
            res_len   <= '0;
            res_ovf   <= 1'b0;
        end else begin
            bit_valid <= accept;
            if (accept) begin
                bit_o <= ab;
                if (in_last) begin
                    res_all <= fin_all;
                    res_any <= fin_any;
                    res_len <= fin_len;
                    res_ovf <= fin_ovf;
                    acc_all <= 1'b1;
                    acc_any <= 1'b0;
                    acc_len <= '0;
                    acc_ovf <= 1'b0;
                end else begin
                    acc_all <= fin_all;
                    acc_any <= fin_any;
                    acc_len <= fin_len;
                    acc_ovf <= fin_ovf;
                end
            end
        end
    end

`ifdef SERIAL_AND_REDUCER_ONES_EN
    logic [LW-1:0] acc_ones;
    logic [LW-1:0] fin_ones;

    assign fin_ones = (ab && acc_ones != LEN_MAX) ? acc_ones + 1'b1 : acc_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_ones <= '0;
            res_ones <= '0;
        end else if (accept) begin
            if (in_last) begin
                res_ones <= fin_ones;
                acc_ones <= '0;
            end else begin
                acc_ones <= fin_ones;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_and_reducer.sv
// Randomized self-checking bench for serial_and_reducer against a packet-level model.
module tb_serial_and_reducer;

    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          a;
    logic          b;
    logic          in_last;
    logic          bit_valid;
    logic          bit_o;
    logic          res_valid;
    logic          res_ready;
    logic          res_all;
    logic          res_any;
    logic [LW-1:0] res_len;
    logic          res_ovf;
`ifdef SERIAL_AND_REDUCER_ONES_EN
    logic [LW-1:0] res_ones;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit pa[$];
    bit pb[$];

    serial_and_reducer #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .bit_valid (bit_valid),
        .bit_o     (bit_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_all   (res_all),
        .res_any   (res_any),
        .res_len   (res_len),
        .res_ovf   (res_ovf)
`ifdef SERIAL_AND_REDUCER_ONES_EN
        ,
        .res_ones  (res_ones)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".bit_valid"}, bit_valid, 0);
        check({tag, ".bit_o"}, bit_o, 0);
        check({tag, ".res_valid"}, res_valid, 0);
        check({tag, ".res_all"}, res_all, 0);
        check({tag, ".res_any"}, res_any, 0);
        check({tag, ".res_len"}, res_len, 0);
        check({tag, ".res_ovf"}, res_ovf, 0);
`ifdef SERIAL_AND_REDUCER_ONES_EN
        check({tag, ".res_ones"}, res_ones, 0);
`endif
    endtask

    task automatic check_results(input string tag, input int e_all,
                                 input int e_any, input int e_len,
                                 input int e_ovf, input int e_ones);
        check({tag, ".res_valid"}, res_valid, 1);
        check({tag, ".res_all"}, res_all, e_all);
        check({tag, ".res_any"}, res_any, e_any);
        check({tag, ".res_len"}, res_len, e_len);
        check({tag, ".res_ovf"}, res_ovf, e_ovf);
`ifdef SERIAL_AND_REDUCER_ONES_EN
        check({tag, ".res_ones"}, res_ones, e_ones);
`else
        if (e_ones < 0) check({tag, ".ones_arg"}, 0, 1);
`endif
    endtask

    // Stream pa/pb as one packet, then hold the result for 'hold' cycles.
    task automatic send(input string tag, input int hold);
        int n;
        int ones;
        int e_all;
        int e_any;
        int e_len;
        int e_ovf;
        int e_ones;
        bit last_bit;
        n = pa.size();
        for (int i = 0; i < n; i++) begin
            check({tag, ".in_ready"}, in_ready, 1);
            in_valid  = 1'b1;
            a         = pa[i];
            b         = pb[i];
            in_last   = (i == n - 1);
            res_ready = 1'($urandom_range(0, 1));
            tick();
            check({tag, ".bit_valid"}, bit_valid, 1);
            check({tag, ".bit_o"}, bit_o, pa[i] & pb[i]);
            if (i < n - 1) check({tag, ".res_valid_early"}, res_valid, 0);
        end
        last_bit = pa[n-1] & pb[n-1];
        ones = 0;
        foreach (pa[i]) ones += int'(pa[i] & pb[i]);
        e_all  = (ones == n) ? 1 : 0;
        e_any  = (ones > 0) ? 1 : 0;
        e_len  = (n > MAX_LEN) ? MAX_LEN : n;
        e_ovf  = (n > MAX_LEN) ? 1 : 0;
        e_ones = (ones > MAX_LEN) ? MAX_LEN : ones;
        check_results(tag, e_all, e_any, e_len, e_ovf, e_ones);
        res_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 1'($urandom_range(0, 1));
            b        = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
            check({tag, ".hold_in_ready"}, in_ready, 0);
            tick();
            check({tag, ".hold_bit_valid"}, bit_valid, 0);
            check({tag, ".hold_bit_o"}, bit_o, last_bit);
            check_results({tag, ".hold"}, e_all, e_any, e_len, e_ovf, e_ones);
        end
        res_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        check({tag, ".release_valid"}, res_valid, 0);
        check({tag, ".release_ready"}, in_ready, 1);
        check({tag, ".release_bit_valid"}, bit_valid, 0);
        res_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic fill(input int n, input int mode);
        pa.delete();
        pb.delete();
        for (int i = 0; i < n; i++) begin
            pa.push_back(mode == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
            pb.push_back(mode == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        tick();
        check_reset_state("rst0");
        in_valid = 1'b1;
        a        = 1'b1;
        b        = 1'b1;
        in_last  = 1'b1;
        tick();
        check_reset_state("rst1");
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check_reset_state("idle0");
        tick();
        check_reset_state("idle1");

        fill(4, 1);
        send("all_ones", 0);

        pa = '{1'b1, 1'b0, 1'b1};
        pb = '{1'b1, 1'b1, 1'b0};
        send("mixed", 0);

        fill(5, 0);
        send("backpressure", 5);
        pa = '{1'b1};
        pb = '{1'b1};
        send("after_bp", 0);

        fill(18, 1);
        send("saturate", 1);
        fill(2, 1);
        send("after_sat", 0);

        fill(6, 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = pa[i];
            b        = pb[i];
            in_last  = 1'b0;
            tick();
        end
        rst       = 1'b1;
        in_last   = 1'b1;
        res_ready = 1'b1;
        tick();
        check_reset_state("mid_rst");
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        pa = '{1'b0};
        pb = '{1'b1};
        send("single", 0);

        fill(3, 1);
        send("hold_rst", 0);
        pa = '{1'b1};
        pb = '{1'b1};
        in_valid = 1'b1;
        a        = 1'b1;
        b        = 1'b1;
        in_last  = 1'b1;
        tick();
        res_ready = 1'b0;
        rst       = 1'b1;
        tick();
        check_reset_state("hold_rst_rst");
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;

        for (int k = 0; k < 12; k++) begin
            fill($urandom_range(1, 20), 0);
            send($sformatf("rand%0d", k), $urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
